lcd_write_sched: RTL and testbench

//  Sequences the LCD write engine (handshake en/data_stop/addr_en, one word per 4 clk) for the full panel.

---
 rtl/lcd_write_sched.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_lcd_write_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_sched.sv
// -----------------------------------------------------------------------------
// lcd_write_sched
//   Sequences an external LCD write engine (en / data_stop / addr_en handshake,
//   one word per 4 clk) for a complete panel bring-up and frame refresh:
//   panel reset pulse, init-table walk from an external ROM (command, data,
//   delay and end entries), then MEMWR + FRAME_PIX pixel bursts on request.
//   This block owns lcd_rs / lcd_data; the engine owns LCD_CS / LCD_WR.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start         : one-cycle pulse, accepted only in IDLE
//   rom_addr      : init ROM address (registered)
//   rom_data      : {type[1:0], payload[DW-1:0]}, valid 1 clk after rom_addr
//   frame_req     : pulse, accepted only in READY
//   pix_data      : current pixel, held by the source until pix_ack
//   pix_ack       : pulse in the clk the engine accepts a pixel word
//   eng_en        : one-cycle burst start to the engine
//   eng_stop      : current word is the last one of the burst
//   eng_addr_en   : engine accepted the current word
//   lcd_rs        : 0 = command, 1 = data
//   lcd_data      : word presented to the panel bus
//   lcd_rst_n     : panel reset pin, active-low
//   init_done     : high from the first entry into READY until rst
//   busy          : high in every state except IDLE and READY
// -----------------------------------------------------------------------------
module lcd_write_sched #(
    parameter int              DW        = 16,
    parameter int              ROM_AW    = 8,
    parameter int              RST_CYC   = 500,
    parameter int              RST_WAIT  = 6000000,
    parameter int              DLY_UNIT  = 50000,
    parameter int              FRAME_PIX = 76800,
    parameter logic [DW-1:0]   MEMWR_CMD = DW'(16'h002C)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DW+1:0]     rom_data,
    input  logic              frame_req,
    input  logic [DW-1:0]     pix_data,
    output logic              pix_ack,
    output logic              eng_en,
    output logic              eng_stop,
    input  logic              eng_addr_en,
    output logic              lcd_rs,
    output logic [DW-1:0]     lcd_data,
    output logic              lcd_rst_n,
    output logic              init_done,
    output logic              busy
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RST_LO = 4'd1;
    localparam logic [3:0] S_RST_HI = 4'd2;
    localparam logic [3:0] S_FETCH  = 4'd3;
    localparam logic [3:0] S_WORD   = 4'd4;
    localparam logic [3:0] S_DELAY  = 4'd5;
    localparam logic [3:0] S_READY  = 4'd6;
    localparam logic [3:0] S_FCMD   = 4'd7;
    localparam logic [3:0] S_FPIX   = 4'd8;

    localparam int              PCW        = $clog2(FRAME_PIX + 1);
    localparam logic [PCW-1:0]  PIX_LAST   = PCW'(FRAME_PIX - 1);
    localparam logic [31:0]     RST_CYC_W  = 32'(RST_CYC);
    localparam logic [31:0]     RST_WAIT_W = 32'(RST_WAIT);
    localparam logic [31:0]     DLY_UNIT_W = 32'(DLY_UNIT);

    logic [3:0]        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              fetch_ph_q, fetch_ph_d;
    logic [PCW-1:0]    pix_cnt_q, pix_cnt_d;
    logic              ld_pix_q, ld_pix_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [DW-1:0]     lcd_data_q, lcd_data_d;
    logic              lcd_rs_q, lcd_rs_d;
    logic              eng_en_q, eng_en_d;
    logic              eng_stop_q, eng_stop_d;
    logic              lcd_rst_n_q, lcd_rst_n_d;
    logic              init_done_q, init_done_d;
    logic              busy_q, busy_d;

    logic [1:0]        rom_type_s;
    logic [DW-1:0]     rom_payload_s;
    logic [31:0]       dly_prod_s;
    logic              rom_last_s;
    logic [3:0]        adv_state_s;
    logic [ROM_AW-1:0] adv_addr_s;
    logic [PCW-1:0]    pix_nxt_s;

    assign rom_type_s    = rom_data[DW+1:DW];
    assign rom_payload_s = rom_data[DW-1:0];
    // Delay length is not overflow-checked; the table author keeps it < 2^32.
    assign dly_prod_s    = 32'(rom_payload_s) * DLY_UNIT_W;
    assign rom_last_s    = (rom_addr_q == {ROM_AW{1'b1}});
    assign pix_nxt_s     = pix_cnt_q + {{(PCW-1){1'b0}}, 1'b1};

    // Where the init walk goes after an entry completes: the top ROM entry
    // ends the table (no wrap), otherwise fetch the next address.
    always_comb begin
        if (rom_last_s) begin
            adv_state_s = S_READY;
            adv_addr_s  = rom_addr_q;
        end else begin
            adv_state_s = S_FETCH;
            adv_addr_s  = rom_addr_q + {{(ROM_AW-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fetch_ph_d  = 1'b0;
        pix_cnt_d   = pix_cnt_q;
        ld_pix_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        eng_en_d    = 1'b0;
        eng_stop_d  = eng_stop_q;
        lcd_rst_n_d = lcd_rst_n_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RST_LO;
                    cnt_d       = RST_CYC_W;
                    lcd_rst_n_d = 1'b0;
                    rom_addr_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RST_LO: begin
                if (cnt_q <= 32'd1) begin
                    state_d     = S_RST_HI;
                    cnt_d       = RST_WAIT_W;
                    lcd_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_RST_HI: begin
                if (cnt_q <= 32'd1) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            // Phase 0 lets the ROM see the address; phase 1 decodes its word.
            S_FETCH: begin
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    case (rom_type_s)
                        2'b00, 2'b01: begin
                            lcd_rs_d   = rom_type_s[0];
                            lcd_data_d = rom_payload_s;
                            eng_en_d   = 1'b1;
                            eng_stop_d = 1'b1;
                            state_d    = S_WORD;
                        end
                        2'b10: begin
                            if (dly_prod_s == 32'd0) begin
                                state_d    = adv_state_s;
                                rom_addr_d = adv_addr_s;
                            end else begin
                                state_d = S_DELAY;
                                cnt_d   = dly_prod_s;
                            end
                        end
                        default: state_d = S_READY;
                    endcase
                end
            end
            S_WORD: begin
                if (eng_addr_en) begin
                    eng_stop_d = 1'b0;
                    state_d    = adv_state_s;
                    rom_addr_d = adv_addr_s;
                end else begin
                    state_d = S_WORD;
                end
            end
            S_DELAY: begin
                if (cnt_q <= 32'd1) begin
                    state_d    = adv_state_s;
                    rom_addr_d = adv_addr_s;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_READY: begin
                if (frame_req) begin
                    state_d    = S_FCMD;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = MEMWR_CMD;
                    eng_en_d   = 1'b1;
                    eng_stop_d = 1'b1;
                end else begin
                    state_d = S_READY;
                end
            end
            // The MEMWR burst is closed by this addr_en, so a new eng_en is legal.
            S_FCMD: begin
                if (eng_addr_en) begin
                    state_d    = S_FPIX;
                    lcd_rs_d   = 1'b1;
                    lcd_data_d = pix_data;
                    eng_en_d   = 1'b1;
                    pix_cnt_d  = '0;
                    eng_stop_d = (PIX_LAST == '0);
                end else begin
                    state_d = S_FCMD;
                end
            end
            // The source presents the next pixel the clk after pix_ack; it is
            // captured one clk later, well before the engine's next accept.
            S_FPIX: begin
                if (ld_pix_q) begin
                    lcd_data_d = pix_data;
                end else begin
                    lcd_data_d = lcd_data_q;
                end
                if (eng_addr_en) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        state_d    = S_READY;
                        eng_stop_d = 1'b0;
                    end else begin
                        pix_cnt_d  = pix_nxt_s;
                        eng_stop_d = (pix_nxt_s == PIX_LAST);
                        ld_pix_d   = 1'b1;
                    end
                end else begin
                    state_d = S_FPIX;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = !((state_d == S_IDLE) || (state_d == S_READY));
        init_done_d = init_done_q | (state_d == S_READY);
    end

    // State and output registers; rst aborts any transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            fetch_ph_q  <= 1'b0;
            pix_cnt_q   <= '0;
            ld_pix_q    <= 1'b0;
            rom_addr_q  <= '0;
            lcd_data_q  <= '0;
            lcd_rs_q    <= 1'b0;
            eng_en_q    <= 1'b0;
            eng_stop_q  <= 1'b0;
            lcd_rst_n_q <= 1'b1;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fetch_ph_q  <= fetch_ph_d;
            pix_cnt_q   <= pix_cnt_d;
            ld_pix_q    <= ld_pix_d;
            rom_addr_q  <= rom_addr_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            eng_en_q    <= eng_en_d;
            eng_stop_q  <= eng_stop_d;
            lcd_rst_n_q <= lcd_rst_n_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    // pix_ack must coincide with the engine's accept, so it is decoded
    // from the registered state rather than delayed a clk.
    assign pix_ack   = (state_q == S_FPIX) && eng_addr_en;
    assign rom_addr  = rom_addr_q;
    assign lcd_data  = lcd_data_q;
    assign lcd_rs    = lcd_rs_q;
    assign eng_en    = eng_en_q;
    assign eng_stop  = eng_stop_q;
    assign lcd_rst_n = lcd_rst_n_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_write_sched.sv
// -----------------------------------------------------------------------------
// tb_lcd_write_sched
//   Drives lcd_write_sched with a behavioural write engine (addr_en 3 clk after
//   en, then every 4 clk until stop), a clocked init ROM and a pixel source.
//   Every word the engine accepts is logged as a panel write; the scenario
//   tasks compare that log against expectations built from the ROM contents,
//   the pixel values and the timing rules.
// -----------------------------------------------------------------------------
module tb_lcd_write_sched;

    localparam int          DW        = 16;
    localparam int          ROM_AW    = 2;
    localparam int          RST_CYC   = 4;
    localparam int          RST_WAIT  = 8;
    localparam int          DLY_UNIT  = 2;
    localparam int          FRAME_PIX = 4;
    localparam logic [15:0] MEMWR     = 16'h002C;

    logic              clk;
    logic              rst;
    logic              start;
    logic              frame_req;
    logic              eng_addr_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [DW+1:0]     rom_data;
    logic [DW-1:0]     pix_data;
    logic              pix_ack;
    logic              eng_en;
    logic              eng_stop;
    logic              lcd_rs;
    logic [DW-1:0]     lcd_data;
    logic              lcd_rst_n;
    logic              init_done;
    logic              busy;

    logic [DW+1:0]     rom_mem [4];
    logic [15:0]       pix_tab [4];
    int                ack_base;

    // environment observations (written only by the env process)
    logic [16:0]       wr_q [$];
    int                wr_cyc [$];
    int                en_cyc [$];
    int                cyc;
    int                en_cnt;
    int                ack_cnt;
    int                en_viol;
    int                lo_cnt;
    int                lo_first;
    int                lo_last;

    int                n_cmp;
    int                n_err;

    lcd_write_sched #(
        .DW(DW), .ROM_AW(ROM_AW), .RST_CYC(RST_CYC), .RST_WAIT(RST_WAIT),
        .DLY_UNIT(DLY_UNIT), .FRAME_PIX(FRAME_PIX), .MEMWR_CMD(MEMWR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr),
        .rom_data(rom_data), .frame_req(frame_req), .pix_data(pix_data),
        .pix_ack(pix_ack), .eng_en(eng_en), .eng_stop(eng_stop),
        .eng_addr_en(eng_addr_en), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
        .lcd_rst_n(lcd_rst_n), .init_done(init_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine, ROM and pixel source: observe each cycle at the falling edge,
    // drive the next cycle's inputs just after the rising edge.
    initial begin : env
        bit                burst_open;
        int                next_ae;
        bit                prev_rn;
        logic [ROM_AW-1:0] s_addr;
        int                idx;
        burst_open  = 1'b0;
        next_ae     = 0;
        prev_rn     = 1'b1;
        eng_addr_en = 1'b0;
        rom_data    = '0;
        pix_data    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            s_addr = rom_addr;
            if (rst) begin
                burst_open = 1'b0;
            end else begin
                if (eng_addr_en) begin
                    wr_q.push_back({lcd_rs, lcd_data});
                    wr_cyc.push_back(cyc);
                    if (eng_stop) burst_open = 1'b0;
                    else next_ae = cyc + 4;
                end
                if (eng_en) begin
                    if (burst_open) en_viol++;
                    burst_open = 1'b1;
                    next_ae    = cyc + 3;
                    en_cnt++;
                    en_cyc.push_back(cyc);
                end
                if (pix_ack) ack_cnt++;
                if (!lcd_rst_n) begin
                    if (prev_rn) lo_first = cyc;
                    lo_last = cyc;
                    lo_cnt++;
                end
            end
            prev_rn = lcd_rst_n;
            @(posedge clk);
            #1;
            rom_data = rom_mem[s_addr];
            idx = ack_cnt - ack_base;
            pix_data = (idx >= 0 && idx < 4) ? pix_tab[idx] : 16'hDEAD;
            eng_addr_en = !rst && burst_open && (next_ae == cyc + 1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1; frame_req = 1'b1;
        @(posedge clk); #1; frame_req = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_init(input int bound);
        for (int i = 0; i < bound && !init_done; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Asynchronous reset assertion away from any clock edge.
    task automatic test_reset(input string tag);
        logic [24:0] obs;
        logic [24:0] exp_v;
        exp_v = {2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        obs = {rom_addr, lcd_data, lcd_rs, eng_en, eng_stop, pix_ack, lcd_rst_n, init_done, busy};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s_same_clk: outputs=%h expected=%h", tag, obs, exp_v);
        end
        repeat (3) @(posedge clk);
        #1;
        obs = {rom_addr, lcd_data, lcd_rs, eng_en, eng_stop, pix_ack, lcd_rst_n, init_done, busy};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s_held: outputs=%h expected=%h", tag, obs, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(2);
    endtask

    // Init walk: CMD, DLY, DATA, END; frame_req during init must be ignored.
    task automatic test_init(input bit spec_rom);
        logic [15:0] c0;
        logic [15:0] d0;
        int          dly;
        int          w0;
        int          e0;
        int          l0;
        if (spec_rom) begin
            c0 = 16'h0011; dly = 3; d0 = 16'h00A5;
        end else begin
            c0 = 16'($urandom); dly = $urandom_range(0, 3); d0 = 16'($urandom);
        end
        rom_mem[0] = {2'b00, c0};
        rom_mem[1] = {2'b10, 16'(dly)};
        rom_mem[2] = {2'b01, d0};
        rom_mem[3] = {2'b11, 16'($urandom)};
        w0 = wr_q.size(); e0 = en_cyc.size(); l0 = lo_cnt;
        pulse_start();
        wait_cycles(5);
        pulse_frame();
        wait_init(400);
        wait_cycles(20);
        n_cmp++;
        if (init_done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL init_done: init_done=%b busy=%b expected 1/0", init_done, busy);
        end
        n_cmp++;
        if (lo_cnt - l0 != RST_CYC || lo_last - lo_first + 1 != RST_CYC) begin
            n_err++;
            $display("FAIL rst_pulse: low_cycles=%0d run=%0d expected %0d", lo_cnt - l0, lo_last - lo_first + 1, RST_CYC);
        end
        n_cmp++;
        if (wr_q.size() - w0 != 2) begin
            n_err++;
            $display("FAIL init_writes: count=%0d expected 2", wr_q.size() - w0);
        end
        n_cmp++;
        if (rom_addr !== 2'd3) begin
            n_err++;
            $display("FAIL init_rom_addr: rom_addr=%0d expected 3", rom_addr);
        end
        if (wr_q.size() >= w0 + 2 && en_cyc.size() >= e0 + 2) begin
            n_cmp++;
            if (wr_q[w0] !== {1'b0, c0} || wr_q[w0+1] !== {1'b1, d0}) begin
                n_err++;
                $display("FAIL init_words: got %h %h expected %h %h", wr_q[w0], wr_q[w0+1], {1'b0, c0}, {1'b1, d0});
            end
            n_cmp++;
            if (en_cyc[e0] != lo_last + RST_WAIT + 2 + 1) begin
                n_err++;
                $display("FAIL first_fetch: en_cycle=%0d expected %0d", en_cyc[e0], lo_last + RST_WAIT + 3);
            end
            n_cmp++;
            if (en_cyc[e0+1] - wr_cyc[w0] != 2 + dly * DLY_UNIT + 2 + 1) begin
                n_err++;
                $display("FAIL delay_gap: gap=%0d expected %0d (dly=%0d)", en_cyc[e0+1] - wr_cyc[w0], 5 + dly * DLY_UNIT, dly);
            end
        end
    endtask

    // One frame of random pixels; optionally a second frame_req mid-burst.
    task automatic test_frame(input bit req_mid);
        logic [16:0] exp_w [5];
        int          w0;
        int          e0;
        int          a0;
        int          l0;
        bit          sent;
        for (int i = 0; i < 4; i++) pix_tab[i] = 16'($urandom);
        ack_base = ack_cnt;
        w0 = wr_q.size(); e0 = en_cnt; a0 = ack_cnt; l0 = lo_cnt;
        exp_w[0] = {1'b0, MEMWR};
        for (int i = 0; i < 4; i++) exp_w[i+1] = {1'b1, pix_tab[i]};
        pulse_frame();
        sent = 1'b0;
        for (int k = 0; k < 200 && wr_q.size() < w0 + 5; k++) begin
            @(posedge clk); #1;
            if (req_mid && !sent && wr_q.size() == w0 + 2) begin
                sent = 1'b1;
                frame_req = 1'b1;
                @(posedge clk); #1;
                frame_req = 1'b0;
            end
        end
        if (!req_mid) pulse_start();
        wait_cycles(20);
        n_cmp++;
        if (wr_q.size() - w0 != 5) begin
            n_err++;
            $display("FAIL frame_count: writes=%0d expected 5", wr_q.size() - w0);
        end
        for (int i = 0; i < 5; i++) begin
            if (wr_q.size() > w0 + i) begin
                n_cmp++;
                if (wr_q[w0+i] !== exp_w[i]) begin
                    n_err++;
                    $display("FAIL frame_word%0d: got %h expected %h", i, wr_q[w0+i], exp_w[i]);
                end
            end
        end
        for (int i = 1; i < 4; i++) begin
            if (wr_cyc.size() > w0 + i + 1) begin
                n_cmp++;
                if (wr_cyc[w0+i+1] - wr_cyc[w0+i] != 4) begin
                    n_err++;
                    $display("FAIL pix_spacing%0d: %0d clk expected 4", i, wr_cyc[w0+i+1] - wr_cyc[w0+i]);
                end
            end
        end
        n_cmp++;
        if (en_cnt - e0 != 2 || ack_cnt - a0 != 4) begin
            n_err++;
            $display("FAIL frame_handshake: eng_en=%0d pix_ack=%0d expected 2/4", en_cnt - e0, ack_cnt - a0);
        end
        n_cmp++;
        if (lo_cnt != l0 || busy !== 1'b0 || init_done !== 1'b1) begin
            n_err++;
            $display("FAIL ready_idle: rst_low=%0d busy=%b init_done=%b expected 0/0/1", lo_cnt - l0, busy, init_done);
        end
    endtask

    // Reset in the middle of a pixel burst.
    task automatic test_mid_reset();
        int w0;
        for (int i = 0; i < 4; i++) pix_tab[i] = 16'($urandom);
        ack_base = ack_cnt;
        w0 = wr_q.size();
        pulse_frame();
        for (int k = 0; k < 100 && wr_q.size() < w0 + 2; k++) begin
            @(posedge clk); #1;
        end
        test_reset("mid_reset");
        wait_cycles(10);
        n_cmp++;
        if (wr_q.size() - w0 != 2 || init_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort: writes=%0d init_done=%b expected 2/0", wr_q.size() - w0, init_done);
        end
    endtask

    // Table without an END entry: walk stops at the top address.
    task automatic test_no_end();
        logic [15:0] c [4];
        int          w0;
        for (int i = 0; i < 4; i++) begin
            c[i] = 16'($urandom);
            rom_mem[i] = {2'b00, c[i]};
        end
        w0 = wr_q.size();
        pulse_start();
        wait_init(400);
        wait_cycles(20);
        n_cmp++;
        if (wr_q.size() - w0 != 4 || rom_addr !== 2'd3 || init_done !== 1'b1) begin
            n_err++;
            $display("FAIL no_end: writes=%0d rom_addr=%0d init_done=%b expected 4/3/1", wr_q.size() - w0, rom_addr, init_done);
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_q.size() > w0 + i) begin
                n_cmp++;
                if (wr_q[w0+i] !== {1'b0, c[i]}) begin
                    n_err++;
                    $display("FAIL no_end_word%0d: got %h expected %h", i, wr_q[w0+i], {1'b0, c[i]});
                end
            end
        end
    endtask

    initial begin : main
        rst = 1'b1; start = 1'b0; frame_req = 1'b0; ack_base = 0;
        for (int i = 0; i < 4; i++) begin
            rom_mem[i] = {2'b11, 16'h0000};
            pix_tab[i] = 16'h0000;
        end
        n_cmp = 0; n_err = 0;
        wait_cycles(3);
        test_reset("reset");
        test_init(1'b1);
        test_frame(1'b0);
        test_frame(1'b1);
        test_frame(1'b0);
        test_mid_reset();
        test_init(1'b0);
        test_frame(1'b0);
        test_reset("reset2");
        test_init(1'b0);
        test_reset("reset3");
        test_no_end();
        test_frame(1'b1);
        n_cmp++;
        if (en_viol != 0) begin
            n_err++;
            $display("FAIL burst_overlap: eng_en during open burst %0d times, expected 0", en_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
